// File: rtl/cook_timer_ctrl.sv
// cook_timer_ctrl: kitchen-timer mode of the watch. Holds an MM:SS BCD
// countdown and sequences it through IDLE / RUN / PAUSE / ALARM from
// single-cycle button pulses and a 1 Hz tick.
//
// Input protocol: every btn_* and tick_1s input is a one-cycle pulse with no
// back-pressure. A pulse is consumed on the clock edge where it is high.
// Its effect appears on the registered outputs after that same edge.
// When several events land in one cycle, clear beats start, start beats tick,
// and tick beats the increment buttons.
module cook_timer_ctrl #(
    parameter int ALARM_SEC = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_1s,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_inc_min,
    input  logic       btn_inc_sec,
    output logic [3:0] min10,
    output logic [3:0] min1,
    output logic [3:0] sec10,
    output logic [3:0] sec1,
    output logic [1:0] state,
    output logic       running,
    output logic       alarm
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ALARM = 2'd3
    } state_t;

    localparam logic [7:0] ALARM_LIMIT = 8'(ALARM_SEC);

    state_t     state_q, state_d;
    logic [3:0] min10_d, min1_d, sec10_d, sec1_d;
    logic [7:0] acnt_q, acnt_d;
    logic       is_zero, is_one;

    // 00:00 blocks a start; 00:01 is the last value before the alarm.
    assign is_zero = (min10 == 4'd0) && (min1 == 4'd0) && (sec10 == 4'd0) && (sec1 == 4'd0);
    assign is_one  = (min10 == 4'd0) && (min1 == 4'd0) && (sec10 == 4'd0) && (sec1 == 4'd1);

    // State exposed for the display mux and for checkers.
    assign state = state_q;

    // Next-state and next-value decode, applying the event priority.
    always_comb begin
        state_d = state_q;
        min10_d = min10;
        min1_d  = min1;
        sec10_d = sec10;
        sec1_d  = sec1;
        acnt_d  = acnt_q;
        case (state_q)
            S_IDLE: begin
                if (btn_clear) begin
                    {min10_d, min1_d, sec10_d, sec1_d} = 16'h0000;
                end else if (btn_start) begin
                    if (!is_zero) state_d = S_RUN;
                end else begin
                    if (btn_inc_sec) begin
                        if (sec1 == 4'd9) begin
                            sec1_d  = 4'd0;
                            sec10_d = (sec10 == 4'd5) ? 4'd0 : sec10 + 4'd1;
                        end else begin
                            sec1_d = sec1 + 4'd1;
                        end
                    end
                    if (btn_inc_min) begin
                        if (min1 == 4'd9) begin
                            min1_d  = 4'd0;
                            min10_d = (min10 == 4'd9) ? 4'd0 : min10 + 4'd1;
                        end else begin
                            min1_d = min1 + 4'd1;
                        end
                    end
                end
            end
            S_RUN: begin
                if (btn_clear) begin
                    state_d = S_IDLE;
                    {min10_d, min1_d, sec10_d, sec1_d} = 16'h0000;
                end else if (btn_start) begin
                    state_d = S_PAUSE;
                end else if (tick_1s) begin
                    // BCD borrow chain; RUN never holds 00:00 so min10 never underflows.
                    if (sec1 != 4'd0) begin
                        sec1_d = sec1 - 4'd1;
                    end else begin
                        sec1_d = 4'd9;
                        if (sec10 != 4'd0) begin
                            sec10_d = sec10 - 4'd1;
                        end else begin
                            sec10_d = 4'd5;
                            if (min1 != 4'd0) begin
                                min1_d = min1 - 4'd1;
                            end else begin
                                min1_d  = 4'd9;
                                min10_d = min10 - 4'd1;
                            end
                        end
                    end
                    if (is_one) begin
                        state_d = S_ALARM;
                        acnt_d  = 8'd0;
                    end
                end
            end
            S_PAUSE: begin
                if (btn_clear) begin
                    state_d = S_IDLE;
                    {min10_d, min1_d, sec10_d, sec1_d} = 16'h0000;
                end else if (btn_start) begin
                    state_d = S_RUN;
                end
            end
            S_ALARM: begin
                if (btn_clear || btn_start) begin
                    state_d = S_IDLE;
                end else if (tick_1s) begin
                    acnt_d = acnt_q + 8'd1;
                    if (acnt_q + 8'd1 == ALARM_LIMIT) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, countdown digits, alarm counter and decoded flags, all registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            min10   <= 4'd0;
            min1    <= 4'd0;
            sec10   <= 4'd0;
            sec1    <= 4'd0;
            acnt_q  <= 8'd0;
            running <= 1'b0;
            alarm   <= 1'b0;
        end else begin
            state_q <= state_d;
            min10   <= min10_d;
            min1    <= min1_d;
            sec10   <= sec10_d;
            sec1    <= sec1_d;
            acnt_q  <= acnt_d;
            running <= (state_d == S_RUN);
            alarm   <= (state_d == S_ALARM);
        end
    end

endmodule
